// File: rtl/axi4s_fifo_arbiter.sv
// Packet-granular round-robin arbiter feeding the AXI4-Stream FIFO input from two producers.
// Define ARB_STATS_EN to build the per-source accepted-beat counters; otherwise beat_cnt0/1 read 0.
module axi4s_fifo_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_BURST   = 16,
  parameter int FIFO_DEPTH  = 1024,
  parameter int HEADROOM    = 16,
  parameter int LEVEL_WIDTH = 11
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [DATA_WIDTH-1:0]  s0_tdata,
  input  logic                   s0_tvalid,
  input  logic                   s0_tlast,
  output logic                   s0_tready,
  input  logic [DATA_WIDTH-1:0]  s1_tdata,
  input  logic                   s1_tvalid,
  input  logic                   s1_tlast,
  output logic                   s1_tready,
  output logic [DATA_WIDTH-1:0]  m_tdata,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  input  logic                   m_tready,
  input  logic [LEVEL_WIDTH-1:0] fifo_level,
  output logic [1:0]             grant,
  output logic [31:0]            beat_cnt0,
  output logic [31:0]            beat_cnt1
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [LEVEL_WIDTH:0] DEPTH_L    = (LEVEL_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [LEVEL_WIDTH:0] HEADROOM_L = (LEVEL_WIDTH+1)'(HEADROOM);
  localparam logic [8:0]           BURST_LAST = 9'(MAX_BURST - 1);

  state_t               state, state_nxt;
  logic                 ptr, ptr_nxt;
  logic [8:0]           burst, burst_nxt;
  logic [LEVEL_WIDTH:0] free;
  logic                 room;
  logic                 sel_valid, sel_last;
  logic                 accept;

  // Over-full level (above FIFO_DEPTH) would wrap the subtraction, so it is excluded explicitly.
  always_comb begin
    free = DEPTH_L - {1'b0, fifo_level};
    room = ({1'b0, fifo_level} <= DEPTH_L) && (free >= HEADROOM_L);
  end

  always_comb begin
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    m_tdata   = '0;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    grant     = 2'b00;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    state_nxt = state;
    ptr_nxt   = ptr;
    burst_nxt = burst;

    case (state)
      IDLE: begin
        burst_nxt = '0;
        if (room && (s0_tvalid || s1_tvalid)) begin
          if (s0_tvalid && (!s1_tvalid || !ptr)) state_nxt = GNT0;
          else                                   state_nxt = GNT1;
        end
      end
      GNT0: begin
        grant     = 2'b01;
        sel_valid = s0_tvalid;
        sel_last  = s0_tlast;
        m_tdata   = s0_tdata;
        s0_tready = m_tready;
      end
      GNT1: begin
        grant     = 2'b10;
        sel_valid = s1_tvalid;
        sel_last  = s1_tlast;
        m_tdata   = s1_tdata;
        s1_tready = m_tready;
      end
      default: state_nxt = IDLE;
    endcase

    m_tvalid = sel_valid;
    m_tlast  = sel_last;
    accept   = sel_valid && m_tready;

    if (state != IDLE && accept) begin
      if (sel_last || burst == BURST_LAST) begin
        state_nxt = IDLE;
        burst_nxt = '0;
        ptr_nxt   = (state == GNT0);
      end else begin
        burst_nxt = burst + 9'd1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
      ptr   <= 1'b0;
      burst <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      burst <= burst_nxt;
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0] cnt0, cnt1;

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (accept && state == GNT0) cnt0 <= cnt0 + 32'd1;
      if (accept && state == GNT1) cnt1 <= cnt1 + 32'd1;
    end
  end

  assign beat_cnt0 = cnt0;
  assign beat_cnt1 = cnt1;
`else
  assign beat_cnt0 = '0;
  assign beat_cnt1 = '0;
`endif

endmodule

// File: tb/tb_axi4s_fifo_arbiter.sv
// Bench for axi4s_fifo_arbiter: directed vector table, hand-written corner sequences,
// and a randomized run scored against an ownership/queue model of the arbitration rules.
module tb_axi4s_fifo_arbiter;

  localparam int DW    = 32;
  localparam int MB    = 16;
  localparam int DEPTH = 1024;
  localparam int HR    = 16;
  localparam int LW    = 11;

  logic          aclk = 1'b0;
  logic          areset;
  logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
  logic          s0_tvalid, s0_tlast, s0_tready;
  logic          s1_tvalid, s1_tlast, s1_tready;
  logic          m_tvalid, m_tlast, m_tready;
  logic [LW-1:0] fifo_level;
  logic [1:0]    grant;
  logic [31:0]   beat_cnt0, beat_cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  axi4s_fifo_arbiter #(
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB),
    .FIFO_DEPTH (DEPTH),
    .HEADROOM   (HR),
    .LEVEL_WIDTH(LW)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .s0_tdata  (s0_tdata),
    .s0_tvalid (s0_tvalid),
    .s0_tlast  (s0_tlast),
    .s0_tready (s0_tready),
    .s1_tdata  (s1_tdata),
    .s1_tvalid (s1_tvalid),
    .s1_tlast  (s1_tlast),
    .s1_tready (s1_tready),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready),
    .fifo_level(fifo_level),
    .grant     (grant),
    .beat_cnt0 (beat_cnt0),
    .beat_cnt1 (beat_cnt1)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          s0v, s0l;
    logic [DW-1:0] s0d;
    logic          s1v, s1l;
    logic [DW-1:0] s1d;
    logic          mr;
    logic [LW-1:0] lvl;
    logic [1:0]    g;
    logic          mv, ml;
    logic [DW-1:0] md;
    logic          r0, r1;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic s0v, input logic s0l, input logic [DW-1:0] s0d,
                              input logic s1v, input logic s1l, input logic [DW-1:0] s1d,
                              input logic mr, input logic [LW-1:0] lvl,
                              input logic [1:0] g, input logic mv, input logic ml,
                              input logic [DW-1:0] md, input logic r0, input logic r1);
    vec_t v;
    v.s0v = s0v; v.s0l = s0l; v.s0d = s0d;
    v.s1v = s1v; v.s1l = s1l; v.s1d = s1d;
    v.mr = mr; v.lvl = lvl;
    v.g = g; v.mv = mv; v.ml = ml; v.md = md; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs;
    s0_tvalid = 0; s0_tlast = 0; s0_tdata = '0;
    s1_tvalid = 0; s1_tlast = 0; s1_tdata = '0;
    m_tready = 1; fifo_level = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    areset = 1;
    tick();
    tick();
    areset = 0;
  endtask

  task automatic chk_outputs(input string tag, input logic [1:0] g, input logic mv,
                             input logic ml, input logic [DW-1:0] md,
                             input logic r0, input logic r1);
    chk({tag, "_grant"},  grant,     g);
    chk({tag, "_mvalid"}, m_tvalid,  mv);
    chk({tag, "_mlast"},  m_tlast,   ml);
    chk({tag, "_mdata"},  m_tdata,   md);
    chk({tag, "_rdy0"},   s0_tready, r0);
    chk({tag, "_rdy1"},   s1_tready, r1);
  endtask

  // Reference model for the random run: who owns the FIFO input and how many beats it has moved.
  int          owner;      // 0 none, 1 source 0, 2 source 1
  int          beats;
  int          pref;       // source favoured on a tie
  int          acc_cnt0, acc_cnt1;
  logic [32:0] q0[$], q1[$];

  task automatic model_cycle(input string tag);
    logic [1:0]    eg;
    logic          emv, eml, er0, er1;
    logic [DW-1:0] emd;
    int            lv;
    bit            room;
    eg = 2'b00; emv = 0; eml = 0; emd = '0; er0 = 0; er1 = 0;
    if (owner == 1) begin
      eg = 2'b01; emv = s0_tvalid; eml = s0_tlast; emd = s0_tdata; er0 = m_tready;
    end else if (owner == 2) begin
      eg = 2'b10; emv = s1_tvalid; eml = s1_tlast; emd = s1_tdata; er1 = m_tready;
    end
    chk_outputs(tag, eg, emv, eml, emd, er0, er1);

    if (owner == 0) begin
      lv   = int'(fifo_level);
      room = (lv <= DEPTH) && (DEPTH - lv >= HR);
      if (room && (s0_tvalid || s1_tvalid)) begin
        owner = (s0_tvalid && (!s1_tvalid || pref == 0)) ? 1 : 2;
        beats = 0;
      end
    end else if (emv && m_tready) begin
      if (owner == 1) begin void'(q0.pop_front()); acc_cnt0++; end
      else            begin void'(q1.pop_front()); acc_cnt1++; end
      beats++;
      if (eml || beats == MB) begin
        pref  = (owner == 1) ? 1 : 0;
        owner = 0;
      end
    end
  endtask

  task automatic push_packet(input int src);
    int len;
    len = $urandom_range(1, 24);
    for (int k = 0; k < len; k++) begin
      if (src == 0) q0.push_back({(k == len - 1), 32'($urandom)});
      else          q1.push_back({(k == len - 1), 32'($urandom)});
    end
  endtask

  logic [1:0] alt_pat[6];
  logic [LW-1:0] lvl_tab[8];

  initial begin
    int i0, i1, k0, k1;
    logic [1:0] eg;
    areset = 1;
    idle_inputs();
    tick();

    // Directed table: 4-beat packet from source 0, then headroom gating of source 1.
    vecs[0]  = mk(1,0,32'h10, 0,0,0,     1,11'd0,    2'b00,0,0,0,     0,0);
    vecs[1]  = mk(1,0,32'h10, 0,0,0,     1,11'd0,    2'b01,1,0,32'h10,1,0);
    vecs[2]  = mk(1,0,32'h11, 0,0,0,     1,11'd0,    2'b01,1,0,32'h11,1,0);
    vecs[3]  = mk(1,0,32'h12, 0,0,0,     1,11'd0,    2'b01,1,0,32'h12,1,0);
    vecs[4]  = mk(1,1,32'h13, 0,0,0,     1,11'd0,    2'b01,1,1,32'h13,1,0);
    vecs[5]  = mk(0,0,0,      0,0,0,     1,11'd0,    2'b00,0,0,0,     0,0);
    vecs[6]  = mk(0,0,0,      1,0,32'hAA,1,11'd1030, 2'b00,0,0,0,     0,0);
    vecs[7]  = mk(0,0,0,      1,0,32'hAA,1,11'd1010, 2'b00,0,0,0,     0,0);
    vecs[8]  = mk(0,0,0,      1,0,32'hAA,1,11'd1010, 2'b00,0,0,0,     0,0);
    vecs[9]  = mk(0,0,0,      1,0,32'hAA,1,11'd1008, 2'b00,0,0,0,     0,0);
    vecs[10] = mk(0,0,0,      1,1,32'hAA,1,11'd1020, 2'b10,1,1,32'hAA,0,1);
    vecs[11] = mk(0,0,0,      0,0,0,     1,11'd0,    2'b00,0,0,0,     0,0);

    do_reset();
    @(negedge aclk);
    chk_outputs("reset", 2'b00, 0, 0, '0, 0, 0);
    chk("reset_cnt0", beat_cnt0, 0);
    chk("reset_cnt1", beat_cnt1, 0);
    tick();

    for (int i = 0; i < 12; i++) begin
      s0_tvalid = vecs[i].s0v; s0_tlast = vecs[i].s0l; s0_tdata = vecs[i].s0d;
      s1_tvalid = vecs[i].s1v; s1_tlast = vecs[i].s1l; s1_tdata = vecs[i].s1d;
      m_tready = vecs[i].mr; fifo_level = vecs[i].lvl;
      @(negedge aclk);
      chk_outputs($sformatf("vec%0d", i), vecs[i].g, vecs[i].mv, vecs[i].ml,
                  vecs[i].md, vecs[i].r0, vecs[i].r1);
      tick();
    end
`ifdef ARB_STATS_EN
    chk("table_cnt0", beat_cnt0, 4);
    chk("table_cnt1", beat_cnt1, 1);
`else
    chk("table_cnt0", beat_cnt0, 0);
    chk("table_cnt1", beat_cnt1, 0);
`endif

    // Both sources continuously offering 2-beat packets: grants alternate with one idle cycle.
    alt_pat = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
    do_reset();
    i0 = 0; i1 = 0;
    for (int c = 0; c < 18; c++) begin
      s0_tvalid = 1; s0_tdata = 32'h100 + 32'(i0); s0_tlast = (i0 % 2 == 1);
      s1_tvalid = 1; s1_tdata = 32'h200 + 32'(i1); s1_tlast = (i1 % 2 == 1);
      @(negedge aclk);
      chk($sformatf("alt%0d_grant", c), grant, alt_pat[c % 6]);
      if (alt_pat[c % 6] == 2'b01) begin
        chk($sformatf("alt%0d_data", c), m_tdata, 32'h100 + 32'(i0));
        i0++;
      end else if (alt_pat[c % 6] == 2'b10) begin
        chk($sformatf("alt%0d_data", c), m_tdata, 32'h200 + 32'(i1));
        i1++;
      end
      tick();
    end

    // 20-beat packet from source 0 is cut after 16 beats; source 1 slips in between.
    do_reset();
    k0 = 0; k1 = 0;
    for (int c = 0; c < 26; c++) begin
      s0_tvalid = (k0 < 20); s0_tdata = 32'h300 + 32'(k0); s0_tlast = (k0 == 19);
      s1_tvalid = (k1 < 2);  s1_tdata = 32'h400 + 32'(k1); s1_tlast = (k1 == 1);
      if (c == 0 || c == 17 || c == 20 || c == 25) eg = 2'b00;
      else if (c == 18 || c == 19)                 eg = 2'b10;
      else                                         eg = 2'b01;
      @(negedge aclk);
      chk($sformatf("burst%0d_grant", c), grant, eg);
      if (eg == 2'b01) begin
        chk($sformatf("burst%0d_data", c), m_tdata, 32'h300 + 32'(k0));
        chk($sformatf("burst%0d_last", c), m_tlast, (k0 == 19));
        k0++;
      end else if (eg == 2'b10) begin
        chk($sformatf("burst%0d_data", c), m_tdata, 32'h400 + 32'(k1));
        k1++;
      end
      tick();
    end

    // Reset mid-grant clears the priority pointer as well as the grant.
    do_reset();
    s0_tvalid = 1; s0_tdata = 32'h50; s0_tlast = 1;
    @(negedge aclk); chk("mrst0_grant", grant, 2'b00); tick();
    @(negedge aclk); chk("mrst1_grant", grant, 2'b01); tick();
    s0_tvalid = 0; s0_tlast = 0; s0_tdata = '0;
    s1_tvalid = 1; s1_tdata = 32'h60; s1_tlast = 0;
    @(negedge aclk); chk("mrst2_grant", grant, 2'b00); tick();
    @(negedge aclk); chk_outputs("mrst3", 2'b10, 1, 0, 32'h60, 0, 1); tick();
    s1_tdata = 32'h61; areset = 1;
    @(negedge aclk); chk_outputs("mrst4", 2'b10, 1, 0, 32'h61, 0, 1); tick();
    areset = 0;
    s0_tvalid = 1; s0_tdata = 32'h70; s1_tdata = 32'h62;
    @(negedge aclk); chk_outputs("mrst5", 2'b00, 0, 0, '0, 0, 0); tick();
    @(negedge aclk); chk_outputs("mrst6", 2'b01, 1, 0, 32'h70, 1, 0); tick();

`ifdef ARB_STATS_EN
    // Counter wrap through 0xFFFFFFFF.
    do_reset();
    force dut.cnt0 = 32'hFFFF_FFFE;
    #1;
    release dut.cnt0;
    for (int c = 0; c < 4; c++) begin
      s0_tvalid = 1; s0_tdata = 32'h80 + 32'(c); s0_tlast = (c == 3);
      tick();
    end
    idle_inputs();
    @(negedge aclk);
    chk("wrap_cnt0", beat_cnt0, 32'h1);
    tick();
`endif

    // Randomized run against the ownership model, then a drain phase.
    lvl_tab = '{11'd0, 11'd700, 11'd1007, 11'd1008, 11'd1009, 11'd1024, 11'd1030, 11'd2047};
    do_reset();
    owner = 0; beats = 0; pref = 0; acc_cnt0 = 0; acc_cnt1 = 0;
    q0.delete(); q1.delete();
    for (int c = 0; c < 7000; c++) begin
      bit drain;
      drain = (c >= 4000);
      if (drain && q0.size() == 0 && q1.size() == 0 && owner == 0) break;
      if (!drain) begin
        if (q0.size() < 4) push_packet(0);
        if (q1.size() < 4) push_packet(1);
      end
      s0_tvalid = (q0.size() > 0) && (drain || $urandom_range(0, 9) < 8);
      s1_tvalid = (q1.size() > 0) && (drain || $urandom_range(0, 9) < 8);
      s0_tdata  = s0_tvalid ? q0[0][31:0] : '0;
      s0_tlast  = s0_tvalid ? q0[0][32]   : 1'b0;
      s1_tdata  = s1_tvalid ? q1[0][31:0] : '0;
      s1_tlast  = s1_tvalid ? q1[0][32]   : 1'b0;
      m_tready  = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
      fifo_level = (drain || $urandom_range(0, 1) == 1) ? 11'd0 : lvl_tab[$urandom_range(0, 7)];
      @(negedge aclk);
      model_cycle($sformatf("rnd%0d", c));
      tick();
    end
`ifdef ARB_STATS_EN
    chk("rnd_cnt0", beat_cnt0, 32'(acc_cnt0));
    chk("rnd_cnt1", beat_cnt1, 32'(acc_cnt1));
`else
    chk("rnd_cnt0", beat_cnt0, 0);
    chk("rnd_cnt1", beat_cnt1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
